// File: rtl/if_fetch.sv
// Instruction-fetch stage: assembles a 32-bit little-endian word from a byte-wide memory port.
// Define ICACHE_EN to add a direct-mapped word cache of ICACHE_DEPTH entries.
module if_fetch #(
  parameter int unsigned ICACHE_DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        pc_ce_i,
  output logic        ready_o,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_rd_o,
  input  logic [7:0]  mem_din_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_valid_o
);

  typedef enum logic [2:0] {
    StIdle, StRd0, StRd1, StRd2, StRd3, StRdLast, StHit, StDone
  } state_e;

  state_e      r_state;
  logic [31:0] r_fetch_pc;
  logic [23:0] r_bytes;
  logic [31:0] r_mem_addr;
  logic        r_mem_rd;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic        r_inst_valid;

  logic        w_hit;
  logic [31:0] w_hit_word;

  if (ICACHE_DEPTH < 2 || (ICACHE_DEPTH & (ICACHE_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ICACHE_DEPTH must be a power of 2");
  end

  assign ready_o      = !flush_i && (r_state == StIdle || (r_state == StDone && !stall_i));
  assign mem_addr_o   = r_mem_addr;
  assign mem_rd_o     = r_mem_rd;
  assign inst_o       = r_inst;
  assign inst_pc_o    = r_inst_pc;
  assign inst_valid_o = r_inst_valid;

`ifdef ICACHE_EN
  localparam int unsigned IdxW = $clog2(ICACHE_DEPTH);
  localparam int unsigned TagW = 30 - IdxW;

  logic [31:0]             r_cdata [ICACHE_DEPTH];
  logic [TagW-1:0]         r_ctag  [ICACHE_DEPTH];
  logic [ICACHE_DEPTH-1:0] r_cvalid;
  logic [IdxW-1:0]         w_lu_idx;
  logic [IdxW-1:0]         w_fp_idx;
  logic                    w_fill;

  assign w_lu_idx   = pc_i[IdxW+1:2];
  assign w_fp_idx   = r_fetch_pc[IdxW+1:2];
  assign w_hit      = (pc_i[1:0] == 2'b00) && r_cvalid[w_lu_idx] &&
                      (r_ctag[w_lu_idx] == pc_i[31:IdxW+2]);
  assign w_hit_word = r_cdata[w_fp_idx];
  // Only a completed, word-aligned byte fetch may allocate.
  assign w_fill     = (r_state == StRdLast) && !flush_i && (r_fetch_pc[1:0] == 2'b00);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cvalid <= '0;
    end else if (w_fill) begin
      r_cvalid[w_fp_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_cdata[w_fp_idx] <= {mem_din_i, r_bytes};
      r_ctag[w_fp_idx]  <= r_fetch_pc[31:IdxW+2];
    end
  end
`else
  assign w_hit      = 1'b0;
  assign w_hit_word = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= StIdle;
      r_fetch_pc   <= '0;
      r_bytes      <= '0;
      r_mem_addr   <= '0;
      r_mem_rd     <= 1'b0;
      r_inst       <= '0;
      r_inst_pc    <= '0;
      r_inst_valid <= 1'b0;
    end else if (flush_i) begin
      r_state      <= StIdle;
      r_mem_rd     <= 1'b0;
      r_inst_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (r_state == StDone && stall_i) begin
            r_mem_rd <= 1'b0;
          end else begin
            // Any held instruction is consumed on this edge.
            r_inst_valid <= 1'b0;
            if (pc_ce_i) begin
              r_fetch_pc <= pc_i;
              if (w_hit) begin
                r_state <= StHit;
              end else begin
                r_mem_addr <= pc_i;
                r_mem_rd   <= 1'b1;
                r_state    <= StRd0;
              end
            end else begin
              r_state <= StIdle;
            end
          end
        end
        StRd0: begin
          r_mem_addr <= r_fetch_pc + 32'd1;
          r_state    <= StRd1;
        end
        StRd1: begin
          r_bytes[7:0] <= mem_din_i;
          r_mem_addr   <= r_fetch_pc + 32'd2;
          r_state      <= StRd2;
        end
        StRd2: begin
          r_bytes[15:8] <= mem_din_i;
          r_mem_addr    <= r_fetch_pc + 32'd3;
          r_state       <= StRd3;
        end
        StRd3: begin
          r_bytes[23:16] <= mem_din_i;
          r_mem_rd       <= 1'b0;
          r_state        <= StRdLast;
        end
        StRdLast: begin
          r_inst       <= {mem_din_i, r_bytes};
          r_inst_pc    <= r_fetch_pc;
          r_inst_valid <= 1'b1;
          r_state      <= StDone;
        end
        StHit: begin
          r_inst       <= w_hit_word;
          r_inst_pc    <= r_fetch_pc;
          r_inst_valid <= 1'b1;
          r_state      <= StDone;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: vector table, directed corner cases and randomized traffic
// checked against a transaction-level model of the fetch stage.
module tb_if_fetch;
  localparam int unsigned Depth = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        pc_ce_i;
  logic        ready_o;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] mem_addr_o;
  logic        mem_rd_o;
  logic [7:0]  mem_din_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;

  always #5 clk = ~clk;

  if_fetch #(.ICACHE_DEPTH(Depth)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .pc_ce_i(pc_ce_i), .ready_o(ready_o),
    .stall_i(stall_i), .flush_i(flush_i), .mem_addr_o(mem_addr_o), .mem_rd_o(mem_rd_o),
    .mem_din_i(mem_din_i), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .inst_valid_o(inst_valid_o)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Memory image: explicit bytes where placed, otherwise an address hash.
  logic [7:0] mem [logic [31:0]];

  function automatic logic [7:0] mb(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ {a[12:8], a[31:29]} ^ 8'hA5;
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {mb(a + 32'd3), mb(a + 32'd2), mb(a + 32'd1), mb(a)};
  endfunction

  // Read data appears the cycle after the address.
  always @(posedge clk) mem_din_i <= mb(mem_addr_o);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Reference model: one pending request counting down edges, plus a presented instruction.
  bit          m_pend, m_hit, m_valid;
  int          m_rem;
  logic [31:0] m_fpc, m_addr, m_inst, m_ipc;
  logic [31:0] m_cache [int];

  function automatic int cidx(input logic [31:0] a);
    return int'((a >> 2) % Depth);
  endfunction

  function automatic bit is_hit(input logic [31:0] a);
`ifdef ICACHE_EN
    return a[1:0] == 2'b00 && m_cache.exists(cidx(a)) && m_cache[cidx(a)] == a;
`else
    return a[0] & 1'b0;
`endif
  endfunction

  function automatic void model_reset();
    m_pend = 0; m_hit = 0; m_valid = 0; m_rem = 0;
    m_fpc = '0; m_addr = '0; m_inst = '0; m_ipc = '0;
    m_cache.delete();
  endfunction

  function automatic void model_step(input logic [31:0] pc, input logic ce, st, fl);
    if (fl) begin
      m_pend = 0; m_valid = 0;
      return;
    end
    if (m_valid && st) return;
    if (m_pend) begin
      m_rem--;
      if (m_rem >= 2) m_addr = m_fpc + 32'(5 - m_rem);
      if (m_rem == 0) begin
        m_pend = 0; m_valid = 1; m_inst = word_at(m_fpc); m_ipc = m_fpc;
`ifdef ICACHE_EN
        if (!m_hit && m_fpc[1:0] == 2'b00) m_cache[cidx(m_fpc)] = m_fpc;
`endif
      end
    end else begin
      m_valid = 0;
      if (ce) begin
        m_fpc = pc; m_pend = 1; m_hit = is_hit(pc); m_rem = m_hit ? 1 : 5;
        if (!m_hit) m_addr = pc;
      end
    end
  endfunction

  logic        s_rdy, s_rd, s_valid;
  logic [31:0] s_addr, s_inst, s_ipc;

  // One clock: drive, sample and check at negedge, advance the model at posedge.
  task automatic cycle(input logic [31:0] pc, input logic ce, st, fl);
    logic exp_rdy, exp_rd;
    pc_i = pc; pc_ce_i = ce; stall_i = st; flush_i = fl;
    @(negedge clk);
    exp_rdy = !fl && !m_pend && !(m_valid && st);
    exp_rd  = m_pend && !m_hit && m_rem >= 2;
    s_rdy = ready_o; s_rd = mem_rd_o; s_valid = inst_valid_o;
    s_addr = mem_addr_o; s_inst = inst_o; s_ipc = inst_pc_o;
    chk("m_ready", 32'(ready_o), 32'(exp_rdy));
    chk("m_rd", 32'(mem_rd_o), 32'(exp_rd));
    chk("m_addr", mem_addr_o, m_addr);
    chk("m_valid", 32'(inst_valid_o), 32'(m_valid));
    chk("m_inst", inst_o, m_inst);
    chk("m_ipc", inst_pc_o, m_ipc);
    @(posedge clk);
    model_step(pc, ce, st, fl);
    #1;
  endtask

  logic [31:0] addrs [8];

  task automatic fetch(input logic [31:0] pc, output int lat, output int nrd);
    lat = -1; nrd = 0;
    cycle(pc, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      cycle(32'h0, 1'b0, 1'b0, 1'b0);
      if (s_rd && nrd < 8) begin
        addrs[nrd] = s_addr;
        nrd++;
      end
      if (s_valid) begin
        lat = k - 1;
        break;
      end
    end
    if (lat < 0) chk("fetch_timeout", 32'(0), 32'(1));
  endtask

  typedef struct {
    logic ce, st, fl; logic [31:0] pc;
    logic rdy, rd, vld; logic [31:0] addr, inst, ipc;
  } vec_t;
  vec_t tv [17];

  function automatic void set_tv(input int i, input logic ce, st, fl, input logic [31:0] pc,
                                 input logic rdy, rd, input logic [31:0] addr,
                                 input logic vld, input logic [31:0] inst, ipc);
    tv[i].ce = ce; tv[i].st = st; tv[i].fl = fl; tv[i].pc = pc;
    tv[i].rdy = rdy; tv[i].rd = rd; tv[i].addr = addr;
    tv[i].vld = vld; tv[i].inst = inst; tv[i].ipc = ipc;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, nrd;
    logic [31:0] rpc;
    logic rce, rst_v, rfl;

    mem[32'h100] = 8'h13; mem[32'h101] = 8'h05; mem[32'h102] = 8'h00; mem[32'h103] = 8'h00;
    mem[32'h104] = 8'h93; mem[32'h105] = 8'h00; mem[32'h106] = 8'h10; mem[32'h107] = 8'h00;

    //        i  ce st fl pc         rdy rd addr      vld inst           ipc
    set_tv(0,  1, 0, 0, 32'h100,   1, 0, 32'h0,   0, 32'h0,        32'h0);
    set_tv(1,  0, 0, 0, 32'h0,     0, 1, 32'h100, 0, 32'h0,        32'h0);
    set_tv(2,  0, 0, 0, 32'h0,     0, 1, 32'h101, 0, 32'h0,        32'h0);
    set_tv(3,  0, 0, 0, 32'h0,     0, 1, 32'h102, 0, 32'h0,        32'h0);
    set_tv(4,  0, 0, 0, 32'h0,     0, 1, 32'h103, 0, 32'h0,        32'h0);
    set_tv(5,  0, 0, 0, 32'h0,     0, 0, 32'h103, 0, 32'h0,        32'h0);
    set_tv(6,  1, 1, 0, 32'h104,   0, 0, 32'h103, 1, 32'h00000513, 32'h100);
    set_tv(7,  1, 1, 0, 32'h104,   0, 0, 32'h103, 1, 32'h00000513, 32'h100);
    set_tv(8,  1, 1, 0, 32'h104,   0, 0, 32'h103, 1, 32'h00000513, 32'h100);
    set_tv(9,  1, 0, 0, 32'h104,   1, 0, 32'h103, 1, 32'h00000513, 32'h100);
    set_tv(10, 0, 0, 0, 32'h0,     0, 1, 32'h104, 0, 32'h0,        32'h0);
    set_tv(11, 0, 0, 0, 32'h0,     0, 1, 32'h105, 0, 32'h0,        32'h0);
    set_tv(12, 0, 0, 0, 32'h0,     0, 1, 32'h106, 0, 32'h0,        32'h0);
    set_tv(13, 0, 0, 0, 32'h0,     0, 1, 32'h107, 0, 32'h0,        32'h0);
    set_tv(14, 0, 0, 0, 32'h0,     0, 0, 32'h107, 0, 32'h0,        32'h0);
    set_tv(15, 0, 0, 0, 32'h0,     1, 0, 32'h107, 1, 32'h00100093, 32'h104);
    set_tv(16, 0, 0, 0, 32'h0,     1, 0, 32'h107, 0, 32'h0,        32'h0);

    // Reset held with a pending request.
    rst = 1'b0; pc_i = 32'h100; pc_ce_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(ready_o), 32'(1));
    chk("rst_rd", 32'(mem_rd_o), 32'(0));
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_valid", 32'(inst_valid_o), 32'(0));
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_ipc", inst_pc_o, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Single fetch, stall in DONE, back-to-back acceptance on release.
    for (int i = 0; i < 17; i++) begin
      cycle(tv[i].pc, tv[i].ce, tv[i].st, tv[i].fl);
      chk($sformatf("tv%0d_ready", i), 32'(s_rdy), 32'(tv[i].rdy));
      chk($sformatf("tv%0d_rd", i), 32'(s_rd), 32'(tv[i].rd));
      chk($sformatf("tv%0d_addr", i), s_addr, tv[i].addr);
      chk($sformatf("tv%0d_valid", i), 32'(s_valid), 32'(tv[i].vld));
      if (tv[i].vld) begin
        chk($sformatf("tv%0d_inst", i), s_inst, tv[i].inst);
        chk($sformatf("tv%0d_ipc", i), s_ipc, tv[i].ipc);
      end
    end

    // Flush during the third read edge of 0x200, then fetch 0x300.
    cycle(32'h200, 1'b1, 1'b0, 1'b0);
    cycle(32'h0, 1'b0, 1'b0, 1'b0);
    cycle(32'h0, 1'b0, 1'b0, 1'b0);
    cycle(32'h0, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("flush_rd", 32'(mem_rd_o), 32'(0));
    chk("flush_valid", 32'(inst_valid_o), 32'(0));
    @(posedge clk);
    #1;
    fetch(32'h300, lat, nrd);
    chk("flush_next_ipc", s_ipc, 32'h300);
    chk("flush_next_inst", s_inst, word_at(32'h300));

    // Address wrap across 2^32.
    fetch(32'hFFFF_FFFE, lat, nrd);
    chk("wrap_lat", 32'(lat), 32'(5));
    chk("wrap_nrd", 32'(nrd), 32'(4));
    chk("wrap_a0", addrs[0], 32'hFFFF_FFFE);
    chk("wrap_a1", addrs[1], 32'hFFFF_FFFF);
    chk("wrap_a2", addrs[2], 32'h0000_0000);
    chk("wrap_a3", addrs[3], 32'h0000_0001);
    chk("wrap_inst", s_inst, word_at(32'hFFFF_FFFE));

    // Asynchronous reset in the middle of a fetch.
    cycle(32'h500, 1'b1, 1'b0, 1'b0);
    cycle(32'h0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("midrst_rd", 32'(mem_rd_o), 32'(0));
    chk("midrst_addr", mem_addr_o, 32'h0);
    chk("midrst_valid", 32'(inst_valid_o), 32'(0));
    chk("midrst_inst", inst_o, 32'h0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (6) cycle(32'h0, 1'b0, 1'b0, 1'b0);

`ifdef ICACHE_EN
    fetch(32'h40, lat, nrd);
    chk("ic_miss_lat", 32'(lat), 32'(5));
    fetch(32'h40, lat, nrd);
    chk("ic_hit_lat", 32'(lat), 32'(1));
    chk("ic_hit_nrd", 32'(nrd), 32'(0));
    chk("ic_hit_inst", s_inst, word_at(32'h40));
    fetch(32'h40 + 32'(4 * Depth), lat, nrd);
    chk("ic_evict_lat", 32'(lat), 32'(5));
    fetch(32'h40, lat, nrd);
    chk("ic_evicted_lat", 32'(lat), 32'(5));
    fetch(32'h42, lat, nrd);
    fetch(32'h42, lat, nrd);
    chk("ic_misal_lat", 32'(lat), 32'(5));
    chk("ic_misal_nrd", 32'(nrd), 32'(4));
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        rpc = $urandom;
      end else begin
        rpc = 32'($urandom_range(0, 15) * 4);
        if ($urandom_range(0, 9) == 0) rpc = rpc + 32'd2;
        if ($urandom_range(0, 3) == 0) rpc = rpc + 32'(4 * Depth);
      end
      rce   = $urandom_range(0, 9) < 7;
      rst_v = $urandom_range(0, 9) < 3;
      rfl   = $urandom_range(0, 19) == 0;
      cycle(rpc, rce, rst_v, rfl);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
